// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks.
//
// Contents:
//   sqrt_state_t - control states of the iterative square root
//   calc_wti     - input integer width rounded up to an even count
//   calc_wri     - integer width of the root (half of calc_wti)
//   calc_niter   - number of iterations needed for n bits at bpc bits/cycle
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  // The integer part is split into bit pairs, so an odd width needs one
  // extra (always zero) bit on top of the magnitude.
  function automatic int calc_wti(input int wii);
    return wii + (wii % 2);
  endfunction

  function automatic int calc_wri(input int wii);
    return calc_wti(wii) / 2;
  endfunction

  function automatic int calc_niter(input int n, input int bpc);
    return (n + bpc - 1) / bpc;
  endfunction

endpackage

// File: rtl/comb_FixedPointZoom.sv
// Combinational signed fixed-point format converter.
//
// Converts a WII.WIF two's-complement value into WOI.WOF. Integer widths
// include the sign bit. Dropped fraction bits are either truncated (floor)
// or rounded to nearest (ties towards +infinity) when ROUND is non-zero.
// Out-of-range values raise upflow/downflow; when ROOF is non-zero the
// output saturates to the nearest representable value, otherwise it wraps.
//
// Ports:
//   in       [WII+WIF-1:0]  signed input value
//   out      [WOI+WOF-1:0]  signed converted value
//   upflow                  converted value above the largest output value
//   downflow                converted value below the smallest output value
module comb_FixedPointZoom #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic [WII+WIF-1:0] in,
  output logic [WOI+WOF-1:0] out,
  output logic               upflow,
  output logic               downflow
);

  localparam int WI   = WII + WIF;
  localparam int WO   = WOI + WOF;
  // Two guard bits: one for the rounding carry, one so the range compare
  // never wraps.
  localparam int WX   = ((WII > WOI) ? WII : WOI) + ((WIF > WOF) ? WIF : WOF) + 2;
  localparam int SH   = (WIF > WOF) ? (WIF - WOF) : 0;
  localparam int SHUP = (WOF > WIF) ? (WOF - WIF) : 0;
  localparam int HALF = (SH > 0) ? (SH - 1) : 0;

  logic signed [WX-1:0] ext;
  logic signed [WX-1:0] bias;
  logic signed [WX-1:0] scaled;
  logic signed [WX-1:0] max_v;
  logic signed [WX-1:0] min_v;

  assign ext = {{(WX-WI){in[WI-1]}}, in};

  always_comb begin
    bias = '0;
    if ((ROUND != 0) && (SH > 0)) begin
      bias = WX'(1) <<< HALF;
    end
    if (SH > 0) begin
      scaled = (ext + bias) >>> SH;
    end else begin
      scaled = ext <<< SHUP;
    end
  end

  always_comb begin
    max_v           = '0;
    max_v[WO-2:0]   = '1;
    min_v           = '1;
    min_v[WO-2:0]   = '0;
  end

  assign upflow   = (scaled > max_v);
  assign downflow = (scaled < min_v);

  always_comb begin
    if ((ROOF != 0) && upflow) begin
      out = max_v[WO-1:0];
    end else if ((ROOF != 0) && downflow) begin
      out = min_v[WO-1:0];
    end else begin
      out = scaled[WO-1:0];
    end
  end

endmodule

// File: rtl/iter_fixed_point_sqrt.sv
// Iterative signed fixed-point square root.
//
// Accepts a WII.WIF signed operand, computes floor(sqrt(|in|)) with WIF
// fraction bits by the restoring (digit-by-digit) method, BPC root bits per
// clock, MSB first. A negative operand yields the negated root. The signed
// root (WRI+1).WIF is converted to WOI.WOF by comb_FixedPointZoom.
//
// Handshake: an operand transfers on a rising edge where i_valid && i_ready;
// a result transfers on a rising edge where o_valid && o_ready. i_ready is
// high only in IDLE, o_valid only in DONE; out/upflow/downflow/exact stay
// stable from the moment o_valid rises until the result transfers.
//
// Ports:
//   clk, rstn          clock (rising edge), synchronous active-low reset
//   i_valid, i_ready   operand handshake
//   in                 signed operand, WII+WIF bits
//   o_valid, o_ready   result handshake
//   out                signed result, WOI+WOF bits
//   upflow, downflow   result above/below the output format range
//   exact              remainder zero: root exactly representable
//   state              current control state (observation only)
module iter_fixed_point_sqrt
  import fixed_point_pkg::*;
#(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [WII+WIF-1:0] in,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [WOI+WOF-1:0] out,
  output logic               upflow,
  output logic               downflow,
  output logic               exact,
  output sqrt_state_t        state
);

  localparam int WI    = WII + WIF;
  localparam int WTI   = calc_wti(WII);
  localparam int WRI   = calc_wri(WII);
  localparam int N     = WRI + WIF;           // root bits
  localparam int NITER = calc_niter(N, BPC);
  localparam int MW    = WTI + WIF;           // magnitude width
  localparam int SW    = 2 * N;               // square width (= MW + WIF)
  localparam int RW    = N + 1;               // signed root width
  localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;

  logic              sign_q;
  logic [MW-1:0]     mag_q;
  logic [N-1:0]      root_q;
  logic [SW-1:0]     sq_q;
  logic [CW-1:0]     cnt_q;

  logic [WI-1:0]     mag_in;
  logic [SW-1:0]     mag_al;
  logic [N-1:0]      root_n;
  logic [SW-1:0]     sq_n;
  logic              last_iter;
  logic [RW-1:0]     root_ext;
  logic [RW-1:0]     res;
  logic [WOI+WOF-1:0] z_out;
  logic              z_up;
  logic              z_dn;

  // Two's-complement magnitude; the most negative operand maps onto the
  // unsigned value 2^(WI-1), which still fits in WI bits.
  assign mag_in = in[WI-1] ? (~in + WI'(1)) : in;

  // The root carries WIF fraction bits, so its square carries 2*WIF; the
  // magnitude is shifted up by WIF to compare on the same binary point.
  assign mag_al = SW'(mag_q) << WIF;

  // Restoring step for root bit k: (root + 2^k)^2 = sq + root*2^(k+1) + 2^(2k).
  // Bits below zero only occur in a final partial iteration and are skipped.
  always_comb begin : p_restore
    int              k;
    logic [SW-1:0]   tent;
    root_n = root_q;
    sq_n   = sq_q;
    k      = 0;
    tent   = '0;
    for (int j = 0; j < BPC; j++) begin
      k = N - 1 - int'(cnt_q) * BPC - j;
      if (k >= 0) begin
        tent = sq_n + (SW'(root_n) << (k + 1)) + (SW'(1) << (2 * k));
        if (tent <= mag_al) begin
          root_n = root_n | (N'(1) << k);
          sq_n   = tent;
        end
      end
    end
  end

  assign last_iter = (cnt_q == CW'(NITER - 1));

  // The converter sees the root as it will be after this cycle's update, so
  // the result registers load on the same edge that enters DONE.
  assign root_ext = RW'(root_n);
  assign res      = sign_q ? (~root_ext + RW'(1)) : root_ext;

  comb_FixedPointZoom #(
    .WII   (WRI + 1),
    .WIF   (WIF),
    .WOI   (WOI),
    .WOF   (WOF),
    .ROOF  (ROOF),
    .ROUND (ROUND)
  ) u_zoom (
    .in       (res),
    .out      (z_out),
    .upflow   (z_up),
    .downflow (z_dn)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      root_q   <= '0;
      sq_q     <= '0;
      out      <= '0;
      upflow   <= 1'b0;
      downflow <= 1'b0;
      exact    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sign_q <= in[WI-1];
            mag_q  <= MW'(mag_in);
            root_q <= '0;
            sq_q   <= '0;
            cnt_q  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          root_q <= root_n;
          sq_q   <= sq_n;
          cnt_q  <= cnt_q + CW'(1);
          if (last_iter) begin
            out      <= z_out;
            upflow   <= z_up;
            downflow <= z_dn;
            exact    <= (sq_n == mag_al);
            state    <= DONE;
          end
        end
        DONE: begin
          if (o_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_iter_fixed_point_sqrt.sv
// Bench for iter_fixed_point_sqrt: seven configurations share one operand
// and handshake stream. Expected results come from a real-arithmetic square
// root model plus hand-computed vectors.
module tb_iter_fixed_point_sqrt;
  import fixed_point_pkg::*;

  localparam int NI = 7;
  localparam int WII_T  [NI] = '{8, 8, 8, 8, 8, 7, 8};
  localparam int WIF_T  [NI] = '{8, 8, 8, 8, 8, 9, 8};
  localparam int WOI_T  [NI] = '{8, 8, 8, 8, 8, 4, 4};
  localparam int WOF_T  [NI] = '{8, 8, 8, 8, 8, 4, 4};
  localparam int ROOF_T [NI] = '{1, 1, 1, 1, 1, 1, 0};
  localparam int ROUND_T[NI] = '{1, 1, 1, 1, 0, 1, 0};
  localparam int BPC_T  [NI] = '{1, 2, 3, 4, 1, 3, 4};
  // Root bits: 4+8=12 for 8.8 inputs, 4+9=13 for the 7.9 input.
  localparam int NITER_T[NI] = '{12, 6, 4, 3, 12, 5, 3};
  localparam int EW = 19;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  logic i_valid;
  logic o_ready;
  logic [15:0] in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_ready  [NI];
  logic        o_valid  [NI];
  logic        upflow   [NI];
  logic        downflow [NI];
  logic        exact    [NI];
  logic [15:0] out_w    [NI];
  sqrt_state_t st       [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WO = WOI_T[g] + WOF_T[g];
    logic [WO-1:0] o;
    iter_fixed_point_sqrt #(
      .WII(WII_T[g]), .WIF(WIF_T[g]), .WOI(WOI_T[g]), .WOF(WOF_T[g]),
      .ROOF(ROOF_T[g]), .ROUND(ROUND_T[g]), .BPC(BPC_T[g])
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .i_valid  (i_valid),
      .i_ready  (i_ready[g]),
      .in       (in),
      .o_valid  (o_valid[g]),
      .o_ready  (o_ready),
      .out      (o),
      .upflow   (upflow[g]),
      .downflow (downflow[g]),
      .exact    (exact[g]),
      .state    (st[g])
    );
    assign out_w[g] = 16'(o);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  logic [15:0] res_out [NI];
  logic        res_up  [NI];
  logic        res_dn  [NI];
  logic        res_ex  [NI];
  int          lat     [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer square root of |x| * 2^WIF, sign applied, then the
  // value rescaled to WOI.WOF with floor or nearest rounding and range check.
  function automatic void model(input int g, input logic [15:0] x,
                                output logic [15:0] o, output logic up,
                                output logic dn, output logic ex);
    longint m, v, r, s, q, mx, mn;
    int sh, w;
    m = x[15] ? (longint'(65536) - longint'(x)) : longint'(x);
    v = m << WIF_T[g];
    r = longint'($floor($sqrt(real'(v))));
    while ((r + 1) * (r + 1) <= v) r++;
    while (r * r > v) r--;
    ex = (r * r == v);
    s  = x[15] ? -r : r;
    sh = WIF_T[g] - WOF_T[g];
    if (sh <= 0) q = s * (longint'(1) << (-sh));
    else if (ROUND_T[g] != 0) q = longint'($floor(real'(s) / real'(longint'(1) << sh) + 0.5));
    else q = longint'($floor(real'(s) / real'(longint'(1) << sh)));
    w  = WOI_T[g] + WOF_T[g];
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    up = (q > mx);
    dn = (q < mn);
    if (ROOF_T[g] != 0 && up) q = mx;
    else if (ROOF_T[g] != 0 && dn) q = mn;
    o = 16'(q & ((longint'(1) << w) - 1));
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [15:0] x, input bit release_after);
    bit all;
    logic [15:0] mo;
    logic mu, md, me;
    logic [EW-1:0] e;
    all = 1'b0;
    for (int n = 0; n < 30; n++) begin
      all = 1'b1;
      for (int g = 0; g < NI; g++) if (!i_ready[g]) all = 1'b0;
      if (all) break;
      @(negedge clk);
    end
    if (!all) check("idle_wait", 0, 1);
    for (int g = 0; g < NI; g++) begin
      model(g, x, mo, mu, md, me);
      exp_q.push_back({mu, md, me, mo});
      lat[g] = 0;
    end
    in = x;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    in = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      all = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (lat[g] == 0) begin
          if (o_valid[g]) begin
            lat[g] = k;
            res_out[g] = out_w[g];
            res_up[g] = upflow[g];
            res_dn[g] = downflow[g];
            res_ex[g] = exact[g];
          end else begin
            all = 1'b0;
          end
        end
      end
      if (all) break;
    end
    for (int g = 0; g < NI; g++) begin
      e = exp_q.pop_front();
      check($sformatf("g%0d_latency x=%0h", g, x), lat[g], NITER_T[g]);
      check($sformatf("g%0d_out x=%0h", g, x), res_out[g], e[15:0]);
      check($sformatf("g%0d_flags x=%0h", g, x), {res_up[g], res_dn[g], res_ex[g]}, e[18:16]);
    end
    if (release_after) begin
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      for (int g = 0; g < NI; g++) check($sformatf("g%0d_idle_after_ready", g), i_ready[g], 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_g%0d_ready", tag, g), {i_ready[g], o_valid[g]}, 2'b10);
      check($sformatf("%s_g%0d_out", tag, g), out_w[g], 0);
      check($sformatf("%s_g%0d_flags", tag, g), {upflow[g], downflow[g], exact[g]}, 0);
    end
    check($sformatf("%s_state", tag), st[0], IDLE);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] x;
    logic [15:0] out;
    logic        ex;
  } vec_t;

  vec_t vt[9];
  logic [15:0] corners[11];

  initial begin
    int bad;
    vt[0] = '{16'h0400, 16'h0200, 1'b1};
    vt[1] = '{16'h0200, 16'h016A, 1'b0};
    vt[2] = '{16'hFC00, 16'hFE00, 1'b1};
    vt[3] = '{16'h8000, 16'hF4B0, 1'b0};
    vt[4] = '{16'h0000, 16'h0000, 1'b1};
    vt[5] = '{16'h0900, 16'h0300, 1'b1};
    vt[6] = '{16'h0100, 16'h0100, 1'b1};
    vt[7] = '{16'h7FFF, 16'h0B50, 1'b0};
    vt[8] = '{16'h0001, 16'h0010, 1'b1};
    corners = '{16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF, 16'h0001, 16'h4000,
                16'hC000, 16'hB000, 16'h0000, 16'h3FFF, 16'h7E00};

    rstn = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    in = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check_reset_state("reset");

    // Hand-computed vectors on the default configuration.
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].x, 1'b1);
      check($sformatf("tbl_out x=%0h", vt[i].x), res_out[0], vt[i].out);
      check($sformatf("tbl_exact x=%0h", vt[i].x), res_ex[0], vt[i].ex);
      if (vt[i].x == 16'h0200) check("tbl_trunc_0200", res_out[4], 16'h016A);
    end

    // Result held while the consumer stalls; operand pulses ignored.
    run_op(16'h0400, 1'b0);
    for (int c = 0; c < 20; c++) begin
      in = 16'($urandom);
      i_valid = c[0];
      @(negedge clk);
      check($sformatf("hold_out c=%0d", c), out_w[0], 16'h0200);
      check($sformatf("hold_hs c=%0d", c), {i_ready[0], o_valid[0], exact[0]}, 3'b011);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    check("hold_release", {i_ready[0], o_valid[0]}, 2'b10);

    // Reset part-way through CALC aborts the operation.
    in = 16'h0400;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_reset_state("abort");
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (o_valid[g]) bad++;
    end
    check("abort_no_result", bad, 0);
    run_op(16'h0900, 1'b1);
    check("after_abort_out", res_out[0], 16'h0300);

    // Corners and random operands against the model.
    for (int i = 0; i < 11; i++) run_op(corners[i], 1'b1);
    for (int i = 0; i < 40; i++) run_op(16'($urandom_range(0, 65535)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
